hdb3_decoder: RTL and testbench
===============================

HDB3_DECODER -- requirements
Module: hdb3_decoder

Interface
REQ-001 SHALL have port i_clk, input, 1, rising-edge clock for all registers.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_en, input, 1, symbol strobe; one line symbol consumed per cycle with i_en=1.
REQ-004 SHALL have port i_hdb3_code, input, 2, line symbol: 2'b01=+1, 2'b10=-1, 2'b00=0, 2'b11=illegal.
REQ-005 SHALL have port i_err_clr, input, 1, synchronous clear of o_err_cnt.
REQ-006 SHALL have port o_data, output, 1, decoded NRZ bit.
REQ-007 SHALL have port o_valid, output, 1, one-cycle strobe qualifying o_data.
REQ-008 SHALL have port o_v_err, output, 1, one-cycle pulse: V-polarity rule broken.
REQ-009 SHALL have port o_code_err, output, 1, one-cycle pulse: illegal symbol or 4 consecutive zeros.
REQ-010 SHALL have port o_err_cnt, output, 16, saturating error count.

Function
REQ-011 SHALL hold all state when i_en=0; o_valid, o_v_err, o_code_err SHALL be 0 in cycles following an edge with i_en=0.
REQ-012 SHALL keep last_pol (polarity of last nonzero symbol) and have_pol flag (set by first nonzero symbol after reset).
REQ-013 SHALL classify a nonzero symbol as V when have_pol=1 and its polarity equals last_pol; otherwise as a mark (decoded 1).
REQ-014 SHALL update last_pol on every nonzero symbol, V or mark; illegal symbols SHALL NOT change last_pol or have_pol.
REQ-015 SHALL keep a 4-bit decoded shift register sr[3:0] (sr[0] newest); on each enabled non-V symbol: sr <= {sr[2:0], bit}, bit=1 for mark, 0 for zero or illegal.
REQ-016 SHALL, on an enabled V symbol, load sr <= 4'b0000, forcing the V and the three preceding decoded positions (000V or B00V) to 0.
REQ-017 SHALL register o_data <= sr[3] on every enabled edge, giving fixed latency: symbol consumed on enabled edge k appears on o_data at enabled edge k+4.
REQ-018 SHALL count enabled symbols after reset (3-bit, saturating at 4); o_valid SHALL pulse on enabled edges only once 4 symbols have previously been consumed, i.e. first o_valid with the 5th symbol.
REQ-019 SHALL keep v_pol/have_v for the last V; a V with have_v=1 and polarity equal to v_pol SHALL pulse o_v_err; the V is still decoded as 0.
REQ-020 SHALL keep a 2-bit zero-run counter, reset by any nonzero or illegal symbol; a 4th consecutive 2'b00 SHALL pulse o_code_err and restart the run at 0.
REQ-021 SHALL pulse o_code_err for 2'b11 symbols.
REQ-022 SHALL increment o_err_cnt by the number of error pulses asserted that cycle (0, 1 or 2), saturating at 16'hFFFF.
REQ-023 SHALL give i_err_clr priority: clear to 0 in that cycle, ignoring same-cycle increments.
REQ-024 SHALL make all outputs registered; no combinational input-to-output path.

Reset
REQ-025 SHALL, on i_rst_n=0, asynchronously clear sr, o_data, o_valid, o_v_err, o_code_err, o_err_cnt, last_pol, have_pol, v_pol, have_v, zero-run and fill counters.
REQ-026 SHALL discard all in-flight symbols on reset mid-stream; first o_valid after release follows REQ-018 afresh.

Verification
REQ-027 SHALL cover reset: assert i_rst_n=0 mid-stream -> all outputs 0 immediately; after release, 4 symbols with no o_valid, then o_valid on 5th.
REQ-028 SHALL cover 000V: i_en=1, symbols 01,00,00,00,01,10 -> o_data sequence 1,0,0,0,0,1, no error pulses.
REQ-029 SHALL cover B00V: symbols 01,10,01,00,00,01,10 -> o_data 1,1,0,0,0,0,1, no errors.
REQ-030 SHALL cover errors: symbol 11 -> o_code_err one pulse, decoded 0, o_err_cnt=1; then 00,00,00,00 -> o_code_err on 4th zero, o_err_cnt=2; two same-polarity V's (01,00,00,00,01,00,00,00,01) -> o_v_err on second V.
REQ-031 SHALL cover counter: force 65535 errors -> o_err_cnt holds 16'hFFFF on next error; i_err_clr with simultaneous error -> o_err_cnt=0.
REQ-032 SHALL cover i_en gaps: repeat REQ-029 stimulus with i_en=0 on alternate cycles -> identical o_data sequence, o_valid only on enabled edges, state held across gaps.

Source files
------------

// File: rtl/hdb3_decoder.sv
// -----------------------------------------------------------------------------
// hdb3_decoder
//
// Decodes a ternary HDB3 line-symbol stream into NRZ data. Bipolar
// violations (V) are recognised by polarity repetition. Each V, together
// with the three decoded positions before it (the 000V / B00V substitution),
// is forced to zero. Line errors are flagged and counted.
//
// The decoded stream leaves through a 4-deep shift register. This gives a
// fixed latency of four enabled symbols, so a substituted B pulse can still
// be cancelled when its V arrives.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_en         symbol strobe; one symbol consumed per enabled edge
//   i_hdb3_code  line symbol: 01 = +1, 10 = -1, 00 = 0, 11 = illegal
//   i_err_clr    synchronous clear of o_err_cnt (wins over increments)
//   o_data       decoded NRZ bit
//   o_valid      one-cycle strobe qualifying o_data
//   o_v_err      one-cycle pulse: two successive V's share a polarity
//   o_code_err   one-cycle pulse: illegal symbol or a fourth consecutive zero
//   o_err_cnt    saturating count of error pulses
// -----------------------------------------------------------------------------
module hdb3_decoder (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [1:0]  i_hdb3_code,
   input  logic        i_err_clr,
   output logic        o_data,
   output logic        o_valid,
   output logic        o_v_err,
   output logic        o_code_err,
   output logic [15:0] o_err_cnt
);

   typedef enum logic [1:0] {
      SYM_ZERO = 2'b00,
      SYM_POS  = 2'b01,
      SYM_NEG  = 2'b10,
      SYM_ILL  = 2'b11
   } sym_t;

   sym_t sym;
   assign sym = sym_t'(i_hdb3_code);

   // Line history; polarity is encoded as 1 = negative.
   logic       last_pol, have_pol;
   logic       v_pol, have_v;
   logic [3:0] sr;
   logic [1:0] zero_run;
   logic [2:0] fill;

   // Per-symbol classification and next-state values
   logic        is_zero, is_nz, is_ill, pol, is_v;
   logic        v_err_nxt, code_err_nxt;
   logic [1:0]  zero_run_nxt;
   logic [3:0]  sr_nxt;
   logic [1:0]  err_inc;
   logic [16:0] cnt_sum;
   logic [15:0] cnt_nxt;

   // NOTE: every signal gets a default at the top of the block. If any path
   // left a signal unassigned, synthesis would infer a latch for it.
   always_comb begin
      is_zero      = 1'b0;
      is_nz        = 1'b0;
      is_ill       = 1'b0;
      pol          = 1'b0;
      is_v         = 1'b0;
      v_err_nxt    = 1'b0;
      code_err_nxt = 1'b0;
      zero_run_nxt = 2'd0;
      sr_nxt       = sr;

      unique case (sym)
         SYM_ZERO: is_zero = 1'b1;
         SYM_POS:  is_nz   = 1'b1;
         SYM_NEG:  begin is_nz = 1'b1; pol = 1'b1; end
         SYM_ILL:  is_ill  = 1'b1;
         default:  is_ill  = 1'b1;
      endcase

      // A pulse that repeats the previous pulse polarity is a violation.
      is_v      = is_nz && have_pol && (pol == last_pol);
      // Consecutive violations must alternate polarity.
      v_err_nxt = is_v && have_v && (pol == v_pol);

      // The 2-bit run counter wraps from 3 to 0 on the fourth zero. The run
      // therefore restarts at the same moment the error is flagged.
      code_err_nxt = is_ill || (is_zero && (zero_run == 2'd3));
      zero_run_nxt = is_zero ? zero_run + 2'd1 : 2'd0;

      // A V clears itself and the three positions before it. Those positions
      // hold the stuffed 000 or B00 of the substitution.
      sr_nxt = is_v ? 4'b0000 : {sr[2:0], is_nz};
   end

   // At most one error pulse can arise per symbol. The adder still allows
   // for two, so the counter stays correct if the error sources ever overlap.
   assign err_inc = i_en ? ({1'b0, v_err_nxt} + {1'b0, code_err_nxt}) : 2'd0;
   assign cnt_sum = {1'b0, o_err_cnt} + {15'd0, err_inc};
   assign cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

   // NOTE: state registers use non-blocking assignments, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr         <= 4'b0000;
         o_data     <= 1'b0;
         o_valid    <= 1'b0;
         o_v_err    <= 1'b0;
         o_code_err <= 1'b0;
         o_err_cnt  <= 16'd0;
         last_pol   <= 1'b0;
         have_pol   <= 1'b0;
         v_pol      <= 1'b0;
         have_v     <= 1'b0;
         zero_run   <= 2'd0;
         fill       <= 3'd0;
      end else begin
         o_err_cnt  <= i_err_clr ? 16'd0 : cnt_nxt;

         // Strobes default low; they only rise on an enabled edge.
         o_valid    <= 1'b0;
         o_v_err    <= 1'b0;
         o_code_err <= 1'b0;

         if (i_en) begin
            o_data     <= sr[3];
            o_valid    <= (fill == 3'd4);
            o_v_err    <= v_err_nxt;
            o_code_err <= code_err_nxt;
            sr         <= sr_nxt;
            zero_run   <= zero_run_nxt;
            if (fill != 3'd4)
               fill <= fill + 3'd1;
            // Illegal symbols leave the polarity history untouched.
            if (is_nz) begin
               last_pol <= pol;
               have_pol <= 1'b1;
            end
            if (is_v) begin
               v_pol  <= pol;
               have_v <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdb3_decoder.sv
// -----------------------------------------------------------------------------
// tb_hdb3_decoder
//
// Directed bench for hdb3_decoder. Every symbol driven pushes its expected
// decoded bit into a scoreboard queue. The entry is popped and compared when
// o_valid is due, four enabled symbols later. Error pulses and the error
// count are checked on the same edge the symbol is consumed.
// -----------------------------------------------------------------------------
module tb_hdb3_decoder;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_en;
   logic [1:0]  i_hdb3_code;
   logic        i_err_clr;
   logic        o_data, o_valid, o_v_err, o_code_err;
   logic [15:0] o_err_cnt;

   hdb3_decoder dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_hdb3_code (i_hdb3_code),
      .i_err_clr   (i_err_clr),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_v_err     (o_v_err),
      .o_code_err  (o_code_err),
      .o_err_cnt   (o_err_cnt)
   );

   always #5 i_clk = ~i_clk;

   int          tests  = 0;
   int          failed = 0;
   logic        sb[$];
   int          nsym;
   logic [15:0] exp_cnt;
   logic        last_exp;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply reset between clock edges. The outputs must clear without an edge.
   task automatic do_reset();
      i_rst_n = 1'b0;
      #1;
      check("rst_data",  {15'd0, o_data},     16'd0);
      check("rst_valid", {15'd0, o_valid},    16'd0);
      check("rst_verr",  {15'd0, o_v_err},    16'd0);
      check("rst_cerr",  {15'd0, o_code_err}, 16'd0);
      check("rst_cnt",   o_err_cnt,           16'd0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst_n  = 1'b1;
      sb.delete();
      nsym     = 0;
      exp_cnt  = 16'd0;
      last_exp = 1'b0;
   endtask

   // One enabled symbol with its expected decoded bit and error pulses
   task automatic send(input logic [1:0] code, input logic exp_bit,
                       input logic exp_v, input logic exp_c);
      logic e;
      i_en        = 1'b1;
      i_hdb3_code = code;
      @(posedge i_clk);
      #1;
      i_en = 1'b0;
      nsym++;
      sb.push_back(exp_bit);
      exp_cnt = exp_cnt + {15'd0, exp_v} + {15'd0, exp_c};
      check("valid", {15'd0, o_valid}, {15'd0, (nsym > 4)});
      if (nsym > 4) begin
         e = sb.pop_front();
         check("data", {15'd0, o_data}, {15'd0, e});
         last_exp = e;
      end
      check("v_err",    {15'd0, o_v_err},    {15'd0, exp_v});
      check("code_err", {15'd0, o_code_err}, {15'd0, exp_c});
      check("err_cnt",  o_err_cnt,           exp_cnt);
   endtask

   // A disabled edge: strobes stay low and all state holds.
   task automatic idle();
      i_en        = 1'b0;
      i_hdb3_code = 2'b11;
      @(posedge i_clk);
      #1;
      check("gap_valid", {15'd0, o_valid},    16'd0);
      check("gap_verr",  {15'd0, o_v_err},    16'd0);
      check("gap_cerr",  {15'd0, o_code_err}, 16'd0);
      check("gap_data",  {15'd0, o_data},     {15'd0, last_exp});
      check("gap_cnt",   o_err_cnt,           exp_cnt);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_en        = 1'b0;
      i_hdb3_code = 2'b00;
      i_err_clr   = 1'b0;
      do_reset();

      // 000V: + 0 0 0 +(V) -, then alternating marks to flush
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b01, 1'b0, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);

      // B00V: + - +(B) 0 0 +(V) -, then flush
      do_reset();
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b01, 1'b0, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);

      // Errors: illegal symbol, four zeros, two same-polarity V's
      do_reset();
      send(2'b11, 1'b0, 1'b0, 1'b1);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b1);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b01, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b0, 1'b0);
      send(2'b01, 1'b0, 1'b1, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);

      // Mid-stream reset while o_valid is high and the count is nonzero.
      // Afterwards, four symbols without o_valid, then o_valid on the fifth.
      do_reset();
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);
      send(2'b10, 1'b1, 1'b0, 1'b0);
      send(2'b01, 1'b1, 1'b0, 1'b0);

      // Saturating counter: 65535 illegal symbols, one more, then clear
      do_reset();
      i_en        = 1'b1;
      i_hdb3_code = 2'b11;
      for (int i = 0; i < 65535; i++) @(posedge i_clk);
      #1;
      check("cnt_full", o_err_cnt, 16'hFFFF);
      @(posedge i_clk);
      #1;
      check("cnt_sat_cerr", {15'd0, o_code_err}, 16'd1);
      check("cnt_sat", o_err_cnt, 16'hFFFF);
      i_err_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_err_clr = 1'b0;
      i_en      = 1'b0;
      check("clr_cerr", {15'd0, o_code_err}, 16'd1);
      check("clr_cnt",  o_err_cnt,           16'd0);

      // B00V with a disabled cycle between every symbol
      do_reset();
      send(2'b01, 1'b1, 1'b0, 1'b0); idle();
      send(2'b10, 1'b1, 1'b0, 1'b0); idle();
      send(2'b01, 1'b0, 1'b0, 1'b0); idle();
      send(2'b00, 1'b0, 1'b0, 1'b0); idle();
      send(2'b00, 1'b0, 1'b0, 1'b0); idle();
      send(2'b01, 1'b0, 1'b0, 1'b0); idle();
      send(2'b10, 1'b1, 1'b0, 1'b0); idle();
      send(2'b01, 1'b1, 1'b0, 1'b0); idle();
      send(2'b10, 1'b1, 1'b0, 1'b0); idle();
      send(2'b01, 1'b1, 1'b0, 1'b0); idle();
      send(2'b10, 1'b1, 1'b0, 1'b0); idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
